// File: rtl/lr_shift_pipe.sv
// lr_shift_pipe: pipelined barrel shifter with a valid/ready stream interface.
// A capture register takes the beat, then S = clog2(width) shift stages follow;
// shift stage k shifts by 2^k when bit k of the beat's amount is set, in the
// mode that travelled with the beat. One global stall holds every stage.
// Configuration macro: LR_SHIFT_PIPE_ROTATE_EN makes mode 11 rotate left;
// without it, mode 11 behaves exactly like LSL and no rotate muxing exists.
module lr_shift_pipe #(
    parameter int width = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    output logic                     i_ready,
    input  logic [width-1:0]         i_bits,
    input  logic [$clog2(width)-1:0] i_shift,
    input  logic [1:0]               i_mode,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [width-1:0]         o_bits
);

    localparam int S = $clog2(width);

    typedef enum logic [1:0] {
        MODE_LSL = 2'b00,
        MODE_LSR = 2'b01,
        MODE_ASR = 2'b10,
        MODE_ROL = 2'b11
    } mode_e;

    // Index 0 is the capture register; index k+1 holds the result of shift stage k.
    logic             valid_q [S+1];
    logic             valid_d [S+1];
    logic [width-1:0] data_q  [S+1];
    logic [width-1:0] data_d  [S+1];
    logic [S-1:0]     shift_q [S];
    logic [S-1:0]     shift_d [S];
    mode_e            mode_q  [S];
    mode_e            mode_d  [S];

    logic advance;

    // One fixed-distance shift step; successive steps compose, so amounts past
    // the width naturally saturate (LSL/LSR to zero, ASR to sign) and rotates wrap.
    function automatic logic [width-1:0] stageShift(input logic [width-1:0] d,
                                                    input mode_e mode,
                                                    input int amt);
        logic [width-1:0] r;
        r = d << amt;
        case (mode)
            MODE_LSR: r = d >> amt;
            MODE_ASR: r = $signed(d) >>> amt;
`ifdef LR_SHIFT_PIPE_ROTATE_EN
            MODE_ROL: r = (d << amt) | (d >> (width - amt));
`endif
            default:  r = d << amt;
        endcase
        return r;
    endfunction

    // The whole pipe moves together unless a finished beat is waiting downstream.
    assign advance = !valid_q[S] || o_ready;
    assign i_ready = advance;
    assign o_valid = valid_q[S];
    assign o_bits  = data_q[S];

    // Next-state for every stage: capture the input, then conditionally shift by 2^k.
    always_comb begin
        valid_d[0] = i_valid;
        data_d[0]  = i_bits;
        shift_d[0] = i_shift;
        mode_d[0]  = mode_e'(i_mode);
        for (int k = 1; k < S; k++) begin
            shift_d[k] = shift_q[k-1];
            mode_d[k]  = mode_q[k-1];
        end
        for (int k = 0; k < S; k++) begin
            valid_d[k+1] = valid_q[k];
            data_d[k+1]  = shift_q[k][k] ? stageShift(data_q[k], mode_q[k], 1 << k)
                                         : data_q[k];
        end
    end

    // Stage registers: cleared asynchronously, loaded only when the pipe advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= S; k++) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= '0;
            end
            for (int k = 0; k < S; k++) begin
                shift_q[k] <= '0;
                mode_q[k]  <= MODE_LSL;
            end
        end else if (advance) begin
            for (int k = 0; k <= S; k++) begin
                valid_q[k] <= valid_d[k];
                data_q[k]  <= data_d[k];
            end
            for (int k = 0; k < S; k++) begin
                shift_q[k] <= shift_d[k];
                mode_q[k]  <= mode_d[k];
            end
        end
    end

endmodule

// File: tb/tb_lr_shift_pipe.sv
// tb_lr_shift_pipe: scoreboard bench for lr_shift_pipe at widths 8, 5 and 32.
`timescale 1ns/1ps
module tb_lr_shift_pipe;

`ifdef LR_SHIFT_PIPE_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    typedef struct {
        logic [31:0] val;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   nCompared = 0;
    int   nMismatched = 0;

    exp_t q8[$];
    exp_t q5[$];
    exp_t q32[$];

    logic        iValid8 = 1'b0, iReady8, oValid8, oReady8 = 1'b1;
    logic [7:0]  iBits8 = '0, oBits8;
    logic [2:0]  iShift8 = '0;
    logic [1:0]  iMode8 = '0;

    logic        iValid5 = 1'b0, iReady5, oValid5, oReady5 = 1'b1;
    logic [4:0]  iBits5 = '0, oBits5;
    logic [2:0]  iShift5 = '0;
    logic [1:0]  iMode5 = '0;

    logic        iValid32 = 1'b0, iReady32, oValid32, oReady32 = 1'b1;
    logic [31:0] iBits32 = '0, oBits32;
    logic [4:0]  iShift32 = '0;
    logic [1:0]  iMode32 = '0;

    lr_shift_pipe #(.width(8)) dut8 (
        .clk(clk), .rst(rst), .i_valid(iValid8), .i_ready(iReady8), .i_bits(iBits8),
        .i_shift(iShift8), .i_mode(iMode8), .o_valid(oValid8), .o_ready(oReady8), .o_bits(oBits8)
    );
    lr_shift_pipe #(.width(5)) dut5 (
        .clk(clk), .rst(rst), .i_valid(iValid5), .i_ready(iReady5), .i_bits(iBits5),
        .i_shift(iShift5), .i_mode(iMode5), .o_valid(oValid5), .o_ready(oReady5), .o_bits(oBits5)
    );
    lr_shift_pipe #(.width(32)) dut32 (
        .clk(clk), .rst(rst), .i_valid(iValid32), .i_ready(iReady32), .i_bits(iBits32),
        .i_shift(iShift32), .i_mode(iMode32), .o_valid(oValid32), .o_ready(oReady32), .o_bits(oBits32)
    );

    // Free-running clock and edge counter.
    always #5 clk = ~clk;

    // Counts rising edges so latencies can be measured in cycles.
    always @(posedge clk) cyc <= cyc + 1;

    // Backstop in case a bounded loop is somehow bypassed.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference: shift one bit position at a time.
    function automatic logic [31:0] refShift(input int w, input logic [31:0] a,
                                             input int sh, input logic [1:0] md);
        logic [31:0] mask, r;
        logic        sign;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        r    = a & mask;
        sign = r[w-1];
        if (md == 2'b11 && ROT) begin
            for (int i = 0; i < sh % w; i++) r = ((r << 1) | {31'd0, r[w-1]}) & mask;
        end else if (md == 2'b01) begin
            for (int i = 0; i < sh; i++) r = r >> 1;
        end else if (md == 2'b10) begin
            for (int i = 0; i < sh; i++) r = (r >> 1) | ({31'd0, sign} << (w - 1));
        end else begin
            for (int i = 0; i < sh; i++) r = (r << 1) & mask;
        end
        return r;
    endfunction

    // One cycle of stimulus on the 8-bit instance; outputs sampled 1ns after the falling edge.
    task automatic applyStimulus8(input logic v, input logic [7:0] b, input logic [2:0] sh,
                                  input logic [1:0] md, input logic ordy,
                                  output logic ov, output logic [7:0] ob, output logic ir);
        @(negedge clk);
        iValid8 = v; iBits8 = b; iShift8 = sh; iMode8 = md; oReady8 = ordy;
        #1;
        ov = oValid8; ob = oBits8; ir = iReady8;
    endtask

    task automatic applyStimulus5(input logic v, input logic [4:0] b, input logic [2:0] sh,
                                  input logic [1:0] md, input logic ordy,
                                  output logic ov, output logic [4:0] ob, output logic ir);
        @(negedge clk);
        iValid5 = v; iBits5 = b; iShift5 = sh; iMode5 = md; oReady5 = ordy;
        #1;
        ov = oValid5; ob = oBits5; ir = iReady5;
    endtask

    task automatic applyStimulus32(input logic v, input logic [31:0] b, input logic [4:0] sh,
                                   input logic [1:0] md, input logic ordy,
                                   output logic ov, output logic [31:0] ob, output logic ir);
        @(negedge clk);
        iValid32 = v; iBits32 = b; iShift32 = sh; iMode32 = md; oReady32 = ordy;
        #1;
        ov = oValid32; ob = oBits32; ir = iReady32;
    endtask

    // Reset state of all instances, during reset and just after release.
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        nCompared += 4;
        if (oValid8 !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset o_valid: got %b want 0", oValid8); end
        if (oBits8 !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset o_bits: got %h want 00", oBits8); end
        if (iReady8 !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset i_ready: got %b want 1", iReady8); end
        if (oValid5 !== 1'b0 || oValid32 !== 1'b0 || oBits32 !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset other widths: got v5=%b v32=%b b32=%h want 0", oValid5, oValid32, oBits32);
        end
        rst = 1'b0;
        #1;
        nCompared++;
        if (iReady8 !== 1'b1) begin nMismatched++; $display("[TB] FAIL post-reset i_ready: got %b want 1", iReady8); end
    endtask

    // 0x96 >> / << 3 in three modes back to back: fixed results, latency 3, consecutive outputs.
    task automatic test_basic_modes();
        logic [7:0] bitsIn [4];
        logic       ov, ir;
        logic [7:0] ob;
        int         sent = 0, got = 0, lastOut = 0;
        exp_t       e;
        bitsIn = '{8'hB0, 8'h12, 8'hF2, ROT ? 8'hB4 : 8'hB0};
        for (int n = 0; n < 40 && got < 4; n++) begin
            applyStimulus8(sent < 4, 8'h96, 3'd3, 2'(sent), 1'b1, ov, ob, ir);
            if (ov) begin
                if (q8.size() == 0) begin
                    nCompared++; nMismatched++;
                    $display("[TB] FAIL basic unexpected output: got %h want none", ob);
                end else begin
                    e = q8.pop_front();
                    nCompared++;
                    if (ob !== e.val[7:0]) begin nMismatched++; $display("[TB] FAIL basic mode %0d data: got %h want %h", got, ob, e.val[7:0]); end
                    nCompared++;
                    if (got == 0 && cyc - e.acc !== 3) begin nMismatched++; $display("[TB] FAIL basic latency: got %0d want 3", cyc - e.acc); end
                    else if (got > 0 && cyc !== lastOut + 1) begin nMismatched++; $display("[TB] FAIL basic spacing: got %0d want %0d", cyc, lastOut + 1); end
                    lastOut = cyc;
                    got++;
                end
            end
            if (sent < 4 && ir) begin
                q8.push_back('{val: {24'd0, bitsIn[sent]}, acc: cyc + 1});
                sent++;
            end
        end
        nCompared++;
        if (got !== 4) begin nMismatched++; $display("[TB] FAIL basic count: got %0d want 4", got); end
    endtask

    // Incrementing data, shift 1 LSL, random o_ready: order, values and stall stability.
    task automatic test_backpressure();
        logic       ov, ir, ordy, prevStall = 1'b0;
        logic [7:0] ob, prevBits = '0, data = 8'h7A;
        int         sent = 0, got = 0;
        exp_t       e;
        for (int n = 0; n < 300 && got < 16; n++) begin
            ordy = 1'($urandom_range(0, 1));
            applyStimulus8(sent < 16, data, 3'd1, 2'b00, ordy, ov, ob, ir);
            if (prevStall) begin
                nCompared++;
                if (ov !== 1'b1 || ob !== prevBits) begin
                    nMismatched++;
                    $display("[TB] FAIL stall hold: got v=%b bits=%h want v=1 bits=%h", ov, ob, prevBits);
                end
            end
            if (ov && !ordy) begin
                nCompared++;
                if (ir !== 1'b0) begin nMismatched++; $display("[TB] FAIL stall i_ready: got %b want 0", ir); end
            end
            if (ov && ordy) begin
                if (q8.size() == 0) begin
                    nCompared++; nMismatched++;
                    $display("[TB] FAIL backpressure duplicate output: got %h want none", ob);
                end else begin
                    e = q8.pop_front();
                    nCompared++;
                    if (ob !== e.val[7:0]) begin nMismatched++; $display("[TB] FAIL backpressure beat %0d: got %h want %h", got, ob, e.val[7:0]); end
                    got++;
                end
            end
            if (sent < 16 && ir) begin
                q8.push_back('{val: refShift(8, {24'd0, data}, 1, 2'b00), acc: cyc + 1});
                sent++;
                data++;
            end
            prevStall = ov && !ordy;
            prevBits  = ob;
        end
        nCompared++;
        if (got !== 16 || q8.size() != 0) begin nMismatched++; $display("[TB] FAIL backpressure count: got %0d want 16", got); end
    endtask

    // Width 5: shift 6 exceeds the width in all four modes.
    task automatic test_non_pow2();
        logic [4:0] expect5 [4];
        logic       ov, ir;
        logic [4:0] ob;
        int         sent = 0, got = 0;
        exp_t       e;
        expect5 = '{5'b00000, 5'b00000, 5'b11111, ROT ? 5'b01101 : 5'b00000};
        for (int n = 0; n < 40 && got < 4; n++) begin
            applyStimulus5(sent < 4, 5'b10110, 3'd6, 2'(sent), 1'b1, ov, ob, ir);
            if (ov) begin
                if (q5.size() == 0) begin
                    nCompared++; nMismatched++;
                    $display("[TB] FAIL width5 unexpected output: got %b want none", ob);
                end else begin
                    e = q5.pop_front();
                    nCompared++;
                    if (ob !== e.val[4:0]) begin nMismatched++; $display("[TB] FAIL width5 mode %0d: got %b want %b", got, ob, e.val[4:0]); end
                    nCompared++;
                    if (got == 0 && cyc - e.acc !== 3) begin nMismatched++; $display("[TB] FAIL width5 latency: got %0d want 3", cyc - e.acc); end
                    got++;
                end
            end
            if (sent < 4 && ir) begin
                q5.push_back('{val: {27'd0, expect5[sent]}, acc: cyc + 1});
                sent++;
            end
        end
        nCompared++;
        if (got !== 4) begin nMismatched++; $display("[TB] FAIL width5 count: got %0d want 4", got); end
    endtask

    // Stalled full pipe, async reset: outputs clear at once, no stale beat, fresh latency 3.
    task automatic test_reset_midflight();
        logic       ov, ir;
        logic [7:0] ob;
        int         got = 0, sent = 0;
        exp_t       e;
        for (int n = 0; n < 3; n++) begin
            applyStimulus8(1'b1, 8'h10 + 8'(n), 3'd1, 2'b00, 1'b0, ov, ob, ir);
        end
        for (int n = 0; n < 10 && !ov; n++) begin
            applyStimulus8(1'b0, 8'h00, 3'd0, 2'b00, 1'b0, ov, ob, ir);
        end
        nCompared++;
        if (ov !== 1'b1) begin nMismatched++; $display("[TB] FAIL midflight fill: got o_valid %b want 1", ov); end
        rst = 1'b1;
        #1;
        nCompared++;
        if (oValid8 !== 1'b0 || oBits8 !== 8'h00 || iReady8 !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL midflight reset: got v=%b bits=%h rdy=%b want v=0 bits=00 rdy=1", oValid8, oBits8, iReady8);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        q8.delete();
        for (int n = 0; n < 40 && got < 1; n++) begin
            applyStimulus8(n >= 6 && sent == 0, 8'hA5, 3'd2, 2'b10, 1'b1, ov, ob, ir);
            if (ov) begin
                if (q8.size() == 0) begin
                    nCompared++; nMismatched++;
                    $display("[TB] FAIL midflight stale beat: got %h want none", ob);
                end else begin
                    e = q8.pop_front();
                    nCompared += 2;
                    if (ob !== e.val[7:0]) begin nMismatched++; $display("[TB] FAIL midflight data: got %h want %h", ob, e.val[7:0]); end
                    if (cyc - e.acc !== 3) begin nMismatched++; $display("[TB] FAIL midflight latency: got %0d want 3", cyc - e.acc); end
                    got++;
                end
            end
            if (n >= 6 && sent == 0 && ir) begin
                q8.push_back('{val: refShift(8, 32'hA5, 2, 2'b10), acc: cyc + 1});
                sent++;
            end
        end
        nCompared++;
        if (got !== 1) begin nMismatched++; $display("[TB] FAIL midflight count: got %0d want 1", got); end
    endtask

    // Width 32: 100 random back-to-back beats at full rate.
    task automatic test_back_to_back();
        logic        ov, ir;
        logic [31:0] ob, b;
        logic [4:0]  sh;
        logic [1:0]  md;
        int          sent = 0, got = 0, lastOut = 0;
        exp_t        e;
        for (int n = 0; n < 300 && got < 100; n++) begin
            b  = $urandom;
            sh = 5'($urandom_range(0, 31));
            md = 2'($urandom_range(0, 3));
            applyStimulus32(sent < 100, b, sh, md, 1'b1, ov, ob, ir);
            if (ov) begin
                if (q32.size() == 0) begin
                    nCompared++; nMismatched++;
                    $display("[TB] FAIL b2b unexpected output: got %h want none", ob);
                end else begin
                    e = q32.pop_front();
                    nCompared += 2;
                    if (ob !== e.val) begin nMismatched++; $display("[TB] FAIL b2b beat %0d: got %h want %h", got, ob, e.val); end
                    if (got == 0 && cyc - e.acc !== 5) begin nMismatched++; $display("[TB] FAIL b2b latency: got %0d want 5", cyc - e.acc); end
                    else if (got > 0 && cyc !== lastOut + 1) begin nMismatched++; $display("[TB] FAIL b2b spacing: got %0d want %0d", cyc, lastOut + 1); end
                    lastOut = cyc;
                    got++;
                end
            end
            if (sent < 100 && ir) begin
                q32.push_back('{val: refShift(32, b, int'(sh), md), acc: cyc + 1});
                sent++;
            end
        end
        nCompared++;
        if (got !== 100) begin nMismatched++; $display("[TB] FAIL b2b count: got %0d want 100", got); end
    endtask

    // Test sequence and summary.
    initial begin
        test_reset();
        test_basic_modes();
        test_backpressure();
        test_non_pow2();
        test_reset_midflight();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/lr_shift_pipe.md
# lr_shift_pipe

Pipelined, parametrised barrel shifter with a valid/ready stream interface. It supports logical left, logical right and arithmetic right shifts, plus an optional rotate-left mode. It is the streaming successor to the combinational left shifter in the datapath library, for use wherever shift results feed registered datapaths under backpressure. One pipeline stage is used per shift-amount bit, so the block closes timing at wide widths.

## Interface
- `width`, default 8: data width in bits; legal range ≥ 2.
- `S` (derived, not overridable): `clog2(width)`. It is the shift-amount width and the pipeline depth.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `i_valid`, input, 1: input beat valid.
- `i_ready`, output, 1: block accepts an input beat this cycle.
- `i_bits`, input, `width`: operand.
- `i_shift`, input, `S`: shift amount.
- `i_mode`, input, 2: operation. 00 = LSL, 01 = LSR, 10 = ASR, 11 = ROL (see Configuration).
- `o_valid`, output, 1: output beat valid.
- `o_ready`, input, 1: downstream accepts output.
- `o_bits`, output, `width`: result.

## Operation
- S register stages. Stage k (k = 0..S-1) applies a shift of 2^k in the beat's mode if `shift[k]` = 1; otherwise the data passes unchanged.
- Each stage holds a valid bit, data, the remaining shift bits and the mode.
- Input transfer: `i_valid && i_ready`. Output transfer: `o_valid && o_ready`.
- Global stall: `advance = !o_valid || o_ready`.
  - `i_ready = advance`, driven combinationally.
  - When `advance` = 1, every stage loads from its predecessor. Stage 0 loads `i_valid` and the input fields.
  - When `advance` = 0, all stages hold.
- Bubbles are not compacted; a bubble occupies a stage like a beat.
- `o_bits` and `o_valid` come directly from the last stage's registers, with no combinational path from the inputs.
- Fill rules:
  - LSL fills with 0 from the LSB.
  - LSR fills with 0 from the MSB.
  - ASR fills with the operand MSB (sign).
- Out-of-range amounts (`i_shift` ≥ `width`, only possible when `width` is not a power of 2):
  - LSL and LSR give all zeros.
  - ASR gives all sign bits.
  - ROL rotates by `i_shift mod width`.
- Stages shift data in the mode captured with the beat, so beats with different modes may be in flight together.

## Timing
- Reset values: all stage valid bits 0, all stage data 0, so `o_valid` = 0 and `o_bits` = 0. `i_ready` = 1 while in reset and immediately after it.
- Latency: a beat accepted at edge n appears with `o_valid` = 1 after edge n+S, provided no stall occurs.
- Throughput: 1 beat per cycle while `o_ready` = 1.
- While `o_valid && !o_ready`:
  - `o_bits` and `o_valid` hold stable.
  - `i_ready` = 0.
  - No beat is lost or duplicated.
- The same cycle that presents `o_ready` = 1 may accept a new input (`i_ready` = 1).
- Reset asserted mid-operation discards all in-flight beats asynchronously. The first beat after reset release sees full latency S.
- `o_valid` = 1 holds the output for as many cycles as the stall lasts. There is no timeout.

## Configuration
- Macro `LR_SHIFT_PIPE_ROTATE_EN`.
- Defined: mode 11 = rotate left; bits shifted out of the MSB re-enter at the LSB.
- Undefined: mode 11 is treated exactly as LSL. The rotate muxing is removed from every stage.

## Test plan
- LSL/LSR/ASR basics (`width` = 8): send `i_bits` = 0x96 with shift 3 in modes 00/01/10 on consecutive cycles, `o_ready` = 1. Required: 0xB0, 0x12, 0xF2 on three consecutive cycles, the first exactly 3 cycles after acceptance.
- Rotate (macro defined, `width` = 8): 0x96, shift 3, mode 11 → 0xB4. With the macro undefined → 0xB0.
- Backpressure: stream 16 beats of incrementing data, shift 1, LSL, while toggling `o_ready` pseudo-randomly. Required:
  - Output sequence equals the inputs × 2 mod 256, in order, with no drops or duplicates.
  - `o_bits` is stable for every cycle in which `o_valid && !o_ready`.
- Non-power-of-2 (`width` = 5, S = 3): 0b10110 with shift 6 → LSL 0, LSR 0, ASR 0b11111. With the macro defined, ROL → 0b01101 (rotate by 1).
- Reset mid-flight: fill the pipeline with 3 beats, assert `rst` for 1 cycle. Required:
  - `o_valid` = 0, `o_bits` = 0, `i_ready` = 1 immediately.
  - No stale beat emerges afterwards.
  - The next beat has latency S.
- Full throughput (`width` = 32, S = 5): 100 back-to-back beats with `o_ready` = 1. Required: 100 outputs on consecutive cycles, with the first 5 cycles after the first acceptance.
